pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and instruction-sequencing FSM for a small
// 16-bit core. Each instruction walks FETCH -> DECODE -> EXEC and then back
// to FETCH. The HALT opcode parks the machine in HALT, and only reset leaves it.
//
// Handshake: fetch_req is high only in FETCH. An instruction word transfers
// on the rising edge where fetch_req and instr_valid are both 1. Outside FETCH,
// instr_valid is ignored. There is no back-pressure on the memory side.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic [15:0] imm,
  input  logic        zero,
  input  logic        stall,
  output logic [15:0] pc,
  output logic        fetch_req,
  output logic [15:0] ir,
  output logic [1:0]  imm_sel,
  output logic        issue,
  output logic        br_taken,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_B    = 2'b00;
  localparam logic [1:0] SEL_C    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  state_t      state, state_nxt;
  logic [3:0]  opcode;
  logic        op_alu, op_bz, op_bnz, op_jmp, op_halt;
  logic [15:0] pc_inc;
  logic [15:0] pc_br;
  logic [15:0] pc_jmp;
  logic        cond_taken;
  logic        exec_go;

  // Opcode decode from the latched instruction register
  always_comb begin
    opcode  = ir[15:12];
    op_alu  = (opcode <= 4'd11);
    op_bz   = (opcode == 4'd12);
    op_bnz  = (opcode == 4'd13);
    op_jmp  = (opcode == 4'd14);
    op_halt = (opcode == 4'd15);
  end

  // Next-PC candidates; additions wrap modulo 2^16 by width
  always_comb begin
    pc_inc     = pc + 16'd1;
    pc_br      = pc_inc + imm;
    pc_jmp     = {pc[15:12], imm[11:0]};
    cond_taken = (op_bz & zero) | (op_bnz & ~zero);
    exec_go    = (state == S_EXEC) && !stall;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = op_halt ? S_HALT : S_EXEC;
      S_EXEC:   if (!stall) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State-derived outputs
  always_comb begin
    fetch_req = (state == S_FETCH);
    halted    = (state == S_HALT);
    state_dbg = state;
  end

  // Datapath registers: pc, ir, imm_sel, and the one-cycle result pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      imm_sel  <= SEL_NONE;
      issue    <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      issue    <= 1'b0;
      br_taken <= 1'b0;
      if (state == S_FETCH && instr_valid) begin
        ir <= instr;
      end
      if (state == S_DECODE) begin
        if (op_alu)                imm_sel <= SEL_B;
        else if (op_bz || op_bnz)  imm_sel <= SEL_C;
        else if (op_jmp)           imm_sel <= SEL_D;
        else                       imm_sel <= SEL_NONE;
      end
      if (exec_go) begin
        if (op_alu) begin
          pc    <= pc_inc;
          issue <= 1'b1;
        end else if (op_bz || op_bnz) begin
          pc       <= cond_taken ? pc_br : pc_inc;
          br_taken <= cond_taken;
        end else if (op_jmp) begin
          pc       <= pc_jmp;
          br_taken <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random instruction streams for pc_sequencer,
// checked against an instruction-level reference model of the PC.
module tb_pc_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] imm;
  logic        zero;
  logic        stall;
  logic [15:0] pc;
  logic        fetch_req;
  logic [15:0] ir;
  logic [1:0]  imm_sel;
  logic        issue;
  logic        br_taken;
  logic        halted;
  logic [1:0]  state_dbg;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_pc;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .imm(imm), .zero(zero), .stall(stall), .pc(pc), .fetch_req(fetch_req),
    .ir(ir), .imm_sel(imm_sel), .issue(issue), .br_taken(br_taken),
    .halted(halted), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Hold reset across one rising edge, check the reset values, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    stall       = 1'b0;
    instr_valid = 1'b0;
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", ir, 16'h0000);
    check("rst_imm_sel", 16'(imm_sel), 16'h0003);
    check("rst_issue", 16'(issue), 16'h0000);
    check("rst_br_taken", 16'(br_taken), 16'h0000);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_fetch_req", 16'(fetch_req), 16'h0001);
    rst_n  = 1'b1;
    exp_pc = RESET_PC;
  endtask

  // Driver + model for one instruction. Call with the DUT in FETCH at a negedge.
  task automatic run_instr(input logic [15:0] word, input logic [15:0] immv,
                           input logic z, input int waits, input int stalls);
    logic [3:0]  op;
    logic [15:0] nxt;
    logic [1:0]  exp_sel;
    logic        exp_iss, exp_br, taken;
    op      = word[15:12];
    exp_iss = 1'b0;
    exp_br  = 1'b0;
    if (op <= 4'd11) begin
      nxt = exp_pc + 16'd1; exp_iss = 1'b1; exp_sel = 2'b00;
    end else if (op == 4'd12 || op == 4'd13) begin
      taken   = (op == 4'd12) ? z : !z;
      nxt     = taken ? exp_pc + 16'd1 + immv : exp_pc + 16'd1;
      exp_br  = taken;
      exp_sel = 2'b01;
    end else if (op == 4'd14) begin
      nxt = {exp_pc[15:12], immv[11:0]}; exp_br = 1'b1; exp_sel = 2'b10;
    end else begin
      nxt = exp_pc; exp_sel = 2'b11;
    end

    check("fetch_req_fetch", 16'(fetch_req), 16'h0001);
    check("pc_fetch", pc, exp_pc);
    for (int i = 0; i < waits; i++) begin
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      @(negedge clk);
      check("fetch_wait_req", 16'(fetch_req), 16'h0001);
      check("fetch_wait_pc", pc, exp_pc);
    end
    instr       = word;
    instr_valid = 1'b1;
    @(negedge clk);
    // DECODE: instr_valid is ignored here, so drive noise on it
    instr_valid = 1'($urandom_range(0, 1));
    instr       = 16'($urandom);
    check("ir_latch", ir, word);
    check("decode_fetch_req", 16'(fetch_req), 16'h0000);
    check("decode_pulses", {14'd0, issue, br_taken}, 16'h0000);

    if (op == 4'd15) begin
      @(negedge clk);
      check("halt_halted", 16'(halted), 16'h0001);
      check("halt_fetch_req", 16'(fetch_req), 16'h0000);
      check("halt_imm_sel", 16'(imm_sel), 16'(exp_sel));
      check("halt_pc", pc, exp_pc);
      return;
    end

    @(negedge clk);
    // EXEC
    imm = immv;
    check("exec_imm_sel", 16'(imm_sel), 16'(exp_sel));
    check("exec_fetch_req", 16'(fetch_req), 16'h0000);
    for (int i = 0; i < stalls; i++) begin
      stall       = 1'b1;
      zero        = 1'(i);
      instr_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_pc", pc, exp_pc);
      check("stall_pulses", {14'd0, issue, br_taken}, 16'h0000);
      check("stall_fetch_req", 16'(fetch_req), 16'h0000);
      check("stall_imm_sel", 16'(imm_sel), 16'(exp_sel));
    end
    stall = 1'b0;
    zero  = z;
    @(negedge clk);
    instr_valid = 1'b0;
    imm         = 16'($urandom);
    zero        = 1'($urandom_range(0, 1));
    check("next_pc", pc, nxt);
    check("issue", 16'(issue), 16'(exp_iss));
    check("br_taken", 16'(br_taken), 16'(exp_br));
    check("back_to_fetch", 16'(fetch_req), 16'h0001);
    exp_pc = nxt;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; imm = '0; zero = 1'b0; stall = 1'b0;
    exp_pc = RESET_PC;
    @(negedge clk);
    do_reset();

    // Fetch handshake with 3 wait cycles, then an ALU instruction
    run_instr(16'h1234, 16'h0000, 1'b0, 3, 0);

    // Backward branch from 0010, taken and not taken
    run_instr(16'hE000, 16'h0010, 1'b0, 0, 0);
    run_instr(16'hC000, 16'hFFFC, 1'b1, 0, 0);
    run_instr(16'hE000, 16'h0010, 1'b0, 1, 0);
    run_instr(16'hC000, 16'hFFFC, 1'b0, 0, 0);

    // Reach 5A00 with a taken BZ, then JMP keeps the top nibble
    run_instr(16'hC000, 16'h5A00 - exp_pc - 16'd1, 1'b1, 0, 0);
    run_instr(16'hE000, 16'hF123, 1'b0, 0, 0);

    // Reach FFFF, then an ALU instruction wraps to 0000
    run_instr(16'hD000, 16'hFFFF - exp_pc - 16'd1, 1'b0, 0, 0);
    run_instr(16'h0ABC, 16'h0000, 1'b0, 0, 0);

    // BNZ stalled 4 cycles with zero toggling, released with zero = 0
    run_instr(16'hD000, 16'h0040, 1'b0, 0, 4);

    // Random instruction stream, HALT excluded
    for (int n = 0; n < 60; n++) begin
      run_instr({4'($urandom_range(0, 14)), 12'($urandom)}, 16'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset mid-EXEC with stall held high
    instr = 16'h3000; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    run_instr(16'h2000, 16'h0000, 1'b0, 0, 0);

    // HALT at 0020 is sticky and ignores instr_valid
    run_instr(16'hE000, 16'h0020, 1'b0, 0, 0);
    run_instr(16'hF000, 16'h0000, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1;
      instr       = 16'($urandom);
      @(negedge clk);
      check("halt_sticky", 16'(halted), 16'h0001);
      check("halt_no_fetch", 16'(fetch_req), 16'h0000);
      check("halt_pc_frozen", pc, 16'h0020);
    end
    do_reset();
    run_instr(16'h5000, 16'h0000, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
